// File: rtl/wide_acc_pkg.sv
// Shared sizing helpers for the wide streaming accumulator.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package wide_acc_pkg;

   // Number of carry-pipeline chunks needed to cover the accumulator.
   function automatic int calc_num_stages(input int acc_width, input int stage_width);
      return (acc_width + stage_width - 1) / stage_width;
   endfunction

   // Width of the most significant chunk (may be narrower than the others).
   function automatic int calc_top_width(input int acc_width, input int stage_width);
      return acc_width - (calc_num_stages(acc_width, stage_width) - 1) * stage_width;
   endfunction

   // Edge-to-edge latency from the accepting edge of a last sample to out_valid:
   // one input register, one adder per chunk along the skew, one output register.
   function automatic int calc_latency(input int acc_width, input int stage_width);
      return calc_num_stages(acc_width, stage_width) + 1;
   endfunction

   localparam int DEFAULT_ACC_WIDTH   = 272;
   localparam int DEFAULT_STAGE_WIDTH = 64;
   localparam int DEFAULT_LATENCY     = calc_latency(DEFAULT_ACC_WIDTH, DEFAULT_STAGE_WIDTH);

endpackage

// File: rtl/acc_chunk_stage.sv
// One chunk of the skewed accumulator: input skew, chunk adder + carry, output deskew.
// Latency: CHUNK_IDX skew cycles in, 1 adder cycle, NUM_STAGES-CHUNK_IDX-1 deskew cycles out.
// Backpressure: none; processes a chunk on every skewed valid.
module acc_chunk_stage
   import wide_acc_pkg::*;
#(
   parameter int CHUNK_IDX  = 0,
   parameter int NUM_STAGES = 1,
   parameter int CW         = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic          in_last,
   input  logic [CW-1:0] in_data,
   input  logic          carry_in,
   output logic          carry_out,
   output logic [CW-1:0] sum_out
);

   // Capture register plus the deskew delay needed to line up with the top chunk.
   localparam int DSK_DEPTH = NUM_STAGES - CHUNK_IDX;

   logic          sk_valid;
   logic          sk_last;
   logic [CW-1:0] sk_data;

   generate
      if (CHUNK_IDX == 0) begin : g_no_skew
         assign sk_valid = in_valid;
         assign sk_last  = in_last;
         assign sk_data  = in_data;
      end else begin : g_skew
         logic [CHUNK_IDX-1:0] v_sr;
         logic [CHUNK_IDX-1:0] l_sr;
         logic [CW-1:0]        d_sr [CHUNK_IDX];

         // Delay the chunk and its flags so it meets the carry from the chunk below.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               v_sr <= '0;
               l_sr <= '0;
               for (int i = 0; i < CHUNK_IDX; i++) d_sr[i] <= '0;
            end else begin
               v_sr[0] <= in_valid;
               l_sr[0] <= in_last;
               d_sr[0] <= in_data;
               for (int i = 1; i < CHUNK_IDX; i++) begin
                  v_sr[i] <= v_sr[i-1];
                  l_sr[i] <= l_sr[i-1];
                  d_sr[i] <= d_sr[i-1];
               end
            end
         end

         assign sk_valid = v_sr[CHUNK_IDX-1];
         assign sk_last  = l_sr[CHUNK_IDX-1];
         assign sk_data  = d_sr[CHUNK_IDX-1];
      end
   endgenerate

   // cont=1 means the next sample continues the current group; cleared by
   // reset and by a last sample so the next group starts from a zero base.
   logic          cont;
   logic [CW-1:0] acc;
   logic [CW-1:0] base;
   logic [CW:0]   full;

   // Chunk adder with registered carry from the chunk below.
   always_comb begin
      base = cont ? acc : '0;
      full = {1'b0, base} + {1'b0, sk_data} + {{CW{1'b0}}, carry_in};
   end

   // Accumulator, carry and group-continuation state; carry is a one-cycle pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc       <= '0;
         carry_out <= 1'b0;
         cont      <= 1'b0;
      end else if (sk_valid) begin
         acc       <= full[CW-1:0];
         carry_out <= full[CW];
         cont      <= ~sk_last;
      end else begin
         carry_out <= 1'b0;
      end
   end

   logic [CW-1:0] dsk [DSK_DEPTH];

   // Capture the closing chunk sum and walk it to the common alignment point.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DSK_DEPTH; i++) dsk[i] <= '0;
      end else begin
         if (sk_valid && sk_last) dsk[0] <= full[CW-1:0];
         for (int i = 1; i < DSK_DEPTH; i++) dsk[i] <= dsk[i-1];
      end
   end

   assign sum_out = dsk[DSK_DEPTH-1];

endmodule

// File: rtl/wide_acc_pipe.sv
// Streaming group accumulator with a chunked, skewed carry chain; emits group sum and count.
// Latency: out_valid NUM_STAGES+1 cycles after the edge accepting the last sample.
// Backpressure: none; accepts a sample every cycle in_valid is high.
module wide_acc_pipe
   import wide_acc_pkg::*;
#(
   parameter int IN_WIDTH    = 256,
   parameter int ACC_WIDTH   = 272,
   parameter int STAGE_WIDTH = 64,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic                 in_last,
   input  logic [IN_WIDTH-1:0]  in_data,
   output logic                 out_valid,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic [CNT_WIDTH-1:0] out_count
);

   localparam int NUM_STAGES = calc_num_stages(ACC_WIDTH, STAGE_WIDTH);
   localparam int TOP_WIDTH  = calc_top_width(ACC_WIDTH, STAGE_WIDTH);
   localparam int LAT_CYCLES = calc_latency(ACC_WIDTH, STAGE_WIDTH);

   logic                 acc_valid;
   logic                 acc_last;
   logic [ACC_WIDTH-1:0] acc_data;

   // Accept register: sign-extend the sample once, qualify last with valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_valid <= 1'b0;
         acc_last  <= 1'b0;
         acc_data  <= '0;
      end else begin
         acc_valid <= in_valid;
         acc_last  <= in_valid & in_last;
         acc_data  <= ACC_WIDTH'($signed(in_data));
      end
   end

   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_next;
   logic [LAT_CYCLES-1:0] last_pipe;
   logic [CNT_WIDTH-1:0] cnt_pipe [LAT_CYCLES];

   // Saturating increment of the running sample count.
   always_comb begin
      cnt_next = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
   end

   // Group sample counter and the count/last delay lines that track the sum pipeline.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         last_pipe <= '0;
         for (int i = 0; i < LAT_CYCLES; i++) cnt_pipe[i] <= '0;
      end else begin
         if (in_valid) cnt <= in_last ? '0 : cnt_next;
         last_pipe[0] <= in_valid & in_last;
         if (in_valid && in_last) cnt_pipe[0] <= cnt_next;
         for (int i = 1; i < LAT_CYCLES; i++) begin
            last_pipe[i] <= last_pipe[i-1];
            cnt_pipe[i]  <= cnt_pipe[i-1];
         end
      end
   end

   logic [NUM_STAGES-1:0] carry;
   logic [ACC_WIDTH-1:0]  sum_aligned;

   generate
      for (genvar k = 0; k < NUM_STAGES; k++) begin : g_chunk
         localparam int CW = (k == NUM_STAGES - 1) ? TOP_WIDTH : STAGE_WIDTH;
         logic cin;

         if (k == 0) begin : g_cin0
            assign cin = 1'b0;
         end else begin : g_cin
            assign cin = carry[k-1];
         end

         acc_chunk_stage #(
            .CHUNK_IDX (k),
            .NUM_STAGES(NUM_STAGES),
            .CW        (CW)
         ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .in_valid (acc_valid),
            .in_last  (acc_last),
            .in_data  (acc_data[k*STAGE_WIDTH +: CW]),
            .carry_in (cin),
            .carry_out(carry[k]),
            .sum_out  (sum_aligned[k*STAGE_WIDTH +: CW])
         );
      end
   endgenerate

   // Carry out of the top chunk is the modulo-2^ACC_WIDTH wrap and is dropped.
   logic unused_top_carry;
   assign unused_top_carry = carry[NUM_STAGES-1];

   // Output register: load sum and count on the aligned last, otherwise hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
      end else begin
         out_valid <= last_pipe[LAT_CYCLES-1];
         if (last_pipe[LAT_CYCLES-1]) begin
            out_sum   <= sum_aligned;
            out_count <= cnt_pipe[LAT_CYCLES-1];
         end
      end
   end

endmodule

// File: tb/tb_wide_acc_pipe.sv
`timescale 1ns/1ps
// Directed and random stimulus for wide_acc_pipe with a queue of expected group results.
module tb_wide_acc_pipe;

   localparam int LAT = 6;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_last;
   logic [255:0] in_data;
   logic         out_valid;
   logic [271:0] out_sum;
   logic [15:0]  out_count;

   wide_acc_pipe dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_last  (in_last),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_sum  (out_sum),
      .out_count(out_count)
   );

   always #5 clk = ~clk;

   int cyc    = 0;
   int errors = 0;
   int checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [271:0] sum;
      logic [15:0]  cnt;
      int           due;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         e;
   logic [271:0] ref_sum  = '0;
   int           ref_cnt  = 0;
   bit           auto_exp = 1'b0;

   task automatic check(input string tag, input logic [271:0] got, input logic [271:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic expect_grp(input logic [271:0] s, input logic [15:0] c);
      exp_q.push_back('{sum: s, cnt: c, due: cyc + LAT});
   endtask

   // Drive one sample for one cycle; returns at the negedge after the accepting edge.
   task automatic send(input logic [255:0] d, input bit last);
      in_valid = 1'b1;
      in_last  = last;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      ref_sum  = ref_sum + {{16{d[255]}}, d};
      ref_cnt  = ref_cnt + 1;
      if (last) begin
         if (auto_exp) expect_grp(ref_sum, 16'(ref_cnt));
         ref_sum = '0;
         ref_cnt = 0;
      end
   endtask

   // Idle cycles; in_last is toggled randomly to show it is ignored without valid.
   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         in_last = 1'($urandom_range(0, 1));
         in_data = {8{$urandom()}};
         @(negedge clk);
      end
      in_last = 1'b0;
   endtask

   // Output monitor: every out_valid must match the head of the expected queue, on time.
   always @(negedge clk) begin
      if (!reset) begin
         if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            check("missing_valid", 272'(out_valid), 272'(1));
            void'(exp_q.pop_front());
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", 272'(out_valid), 272'(0));
            end else begin
               e = exp_q.pop_front();
               check("latency", 272'(cyc), 272'(e.due));
               check("sum", out_sum, e.sum);
               check("count", 272'(out_count), 272'(e.cnt));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   logic [255:0] rnd;
   int           remaining;
   int           glen;

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      repeat (3) @(negedge clk);
      check("reset_valid", 272'(out_valid), 272'(0));
      check("reset_sum", out_sum, 272'(0));
      check("reset_count", 272'(out_count), 272'(0));
      reset = 1'b0;
      idle(2);

      // 1: small group 5, -3, 10
      send(256'd5, 1'b0);
      send(-256'sd3, 1'b0);
      send(256'd10, 1'b1);
      expect_grp(272'd12, 16'd3);
      idle(10);
      check("hold_valid", 272'(out_valid), 272'(0));
      check("hold_sum", out_sum, 272'd12);
      check("hold_count", 272'(out_count), 272'(3));

      // 2: carry from chunk 0 into chunk 1, then through chunks 1..3
      send({192'd0, {64{1'b1}}}, 1'b0);
      send(256'd1, 1'b1);
      expect_grp(272'd1 << 64, 16'd2);
      send({64'd0, {192{1'b1}}}, 1'b0);
      send(256'd1, 1'b1);
      expect_grp(272'd1 << 192, 16'd2);
      idle(10);

      // 3: most negative twice, then most positive 64 times
      send({1'b1, 255'd0}, 1'b0);
      send({1'b1, 255'd0}, 1'b1);
      expect_grp({16'hFFFF, 256'd0}, 16'd2);
      for (int i = 0; i < 64; i++) send({1'b0, {255{1'b1}}}, i == 63);
      expect_grp((272'd1 << 261) - 272'd64, 16'd64);
      idle(10);

      // 4: eight single-sample groups back to back
      for (int i = 1; i <= 8; i++) begin
         send(256'(i), 1'b1);
         expect_grp(272'(i), 16'd1);
      end
      idle(10);

      // 5: bubbles inside a group, then reset discarding a partial group
      send(256'd7, 1'b0);
      idle(3);
      send(256'd9, 1'b1);
      expect_grp(272'd16, 16'd2);
      idle(10);
      send(256'd100, 1'b0);
      #2;
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 256'd200;
      exp_q.delete();
      ref_sum  = '0;
      ref_cnt  = 0;
      #1;
      check("midrst_valid", 272'(out_valid), 272'(0));
      check("midrst_sum", out_sum, 272'(0));
      check("midrst_count", 272'(out_count), 272'(0));
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b0;
      idle(8);
      check("postrst_sum", out_sum, 272'(0));
      send(256'd4, 1'b1);
      expect_grp(272'd4, 16'd1);
      idle(10);

      // 6: random groups with random gaps, checked against the running model
      auto_exp  = 1'b1;
      remaining = 500;
      while (remaining > 0) begin
         glen = $urandom_range(1, 20);
         if (glen > remaining) glen = remaining;
         for (int j = 0; j < glen; j++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            for (int w = 0; w < 8; w++) rnd[w*32 +: 32] = $urandom();
            send(rnd, j == glen - 1);
         end
         remaining = remaining - glen;
      end
      idle(12);
      check("drain", 272'(exp_q.size()), 272'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
